// File: rtl/ssd_scan_ctrl.sv
// Four-digit common-anode seven-segment scan controller with per-slot dead-time
// blanking and frame-synchronous data updates (load -> pending -> shadow).
module ssd_scan_ctrl #(
    parameter int DIGIT_CYC = 100000,
    parameter int BLANK_CYC = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value,
    input  logic [3:0]  digit_en,
    input  logic [3:0]  dp_in,
    input  logic        load,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        busy,
    output logic        frame_tick
);

    localparam int CW = (DIGIT_CYC > 1) ? $clog2(DIGIT_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(DIGIT_CYC - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYC);

    typedef enum logic {
        S_BLANK,
        S_DRIVE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic          frame_end;

    logic [15:0]   pend_value, shad_value;
    logic [3:0]    pend_en, shad_en;
    logic [3:0]    pend_dp, shad_dp;

    logic [3:0]    an_d;
    logic [6:0]    seg_d;
    logic          dp_d;
    logic          tick_d;

    // Active-low gfedcba pattern for one hex nibble.
    function automatic logic [6:0] decode(input logic [3:0] nib);
        case (nib)
            4'h0: decode = 7'b1000000;
            4'h1: decode = 7'b1111001;
            4'h2: decode = 7'b0100100;
            4'h3: decode = 7'b0110000;
            4'h4: decode = 7'b0011001;
            4'h5: decode = 7'b0010010;
            4'h6: decode = 7'b0000010;
            4'h7: decode = 7'b1111000;
            4'h8: decode = 7'b0000000;
            4'h9: decode = 7'b0010000;
            4'hA: decode = 7'b0001000;
            4'hB: decode = 7'b0000011;
            4'hC: decode = 7'b1000110;
            4'hD: decode = 7'b0100001;
            4'hE: decode = 7'b0000110;
            default: decode = 7'b0001110;
        endcase
    endfunction

    // Outputs are registered from the next-cycle state so the pins line up with
    // the current cycle without an extra pipeline stage.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        state_d = state_q;
        an_d    = 4'b1111;
        seg_d   = 7'b1111111;
        dp_d    = 1'b1;

        frame_end = (cnt_q == CNT_LAST) && (idx_q == 2'd3);
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end

        case (state_q)
            S_BLANK: if (cnt_d == CNT_BLANK) state_d = S_DRIVE;
            S_DRIVE: if (cnt_q == CNT_LAST)  state_d = S_BLANK;
            default: state_d = S_BLANK;
        endcase

        tick_d = (cnt_d == CNT_LAST) && (idx_d == 2'd3);

        // A disabled digit stays fully dark, segments and point included.
        if (state_d == S_DRIVE && shad_en[idx_d]) begin
            an_d[idx_d] = 1'b0;
            seg_d       = decode(shad_value[{idx_d, 2'b00} +: 4]);
            dp_d        = ~shad_dp[idx_d];
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q    <= S_BLANK;
            cnt_q      <= '0;
            idx_q      <= '0;
            an         <= 4'b1111;
            seg        <= 7'b1111111;
            dp         <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            an         <= an_d;
            seg        <= seg_d;
            dp         <= dp_d;
            frame_tick <= tick_d;
        end
    end

    // NOTE: the data registers are explicitly reset so the display is dark
    // until the first load, not showing power-up garbage.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_value <= '0;
            pend_en    <= '0;
            pend_dp    <= '0;
            shad_value <= '0;
            shad_en    <= '0;
            shad_dp    <= '0;
            busy       <= 1'b0;
        end else if (frame_end) begin
            // A load landing on the boundary goes straight through; pending
            // follows so the next boundary does not revert it.
            busy <= 1'b0;
            if (load) begin
                pend_value <= value;
                pend_en    <= digit_en;
                pend_dp    <= dp_in;
                shad_value <= value;
                shad_en    <= digit_en;
                shad_dp    <= dp_in;
            end else begin
                shad_value <= pend_value;
                shad_en    <= pend_en;
                shad_dp    <= pend_dp;
            end
        end else if (load) begin
            pend_value <= value;
            pend_en    <= digit_en;
            pend_dp    <= dp_in;
            busy       <= 1'b1;
        end
    end

endmodule
